// File: rtl/initiator_port.sv
// Serial bus initiator: shifts a 16-bit address and optional 8-bit write data out LSB first,
// then waits for a write ack or collects 8 serial read bits, with an idle-cycle timeout.
module initiator_port #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [15:0] init_addr,
  input  logic [7:0]  init_wdata,
  input  logic        init_rw,
  input  logic        bus_data_in,
  input  logic        bus_data_in_valid,
  input  logic        bus_target_ack,
  output logic        bus_data_out,
  output logic        bus_data_out_valid,
  output logic        bus_mode,
  output logic        bus_rw,
  output logic        init_busy,
  output logic [7:0]  init_rdata,
  output logic        init_rdata_valid,
  output logic        init_done,
  output logic        init_error
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RXC_W  = 3;
  localparam int unsigned TMO_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT_ACK,
    S_RDATA
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [RXC_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rw_q, rw_d;
  logic                data_out_q, data_out_d;
  logic                data_out_valid_q, data_out_valid_d;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                tmo_hit;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      bit_cnt_q        <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      rx_q             <= '0;
      rx_cnt_q         <= '0;
      tmo_q            <= '0;
      rw_q             <= 1'b0;
      data_out_q       <= 1'b0;
      data_out_valid_q <= 1'b0;
      mode_q           <= 1'b0;
      busy_q           <= 1'b0;
      rdata_q          <= '0;
      rdata_valid_q    <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      rx_q             <= rx_d;
      rx_cnt_q         <= rx_cnt_d;
      tmo_q            <= tmo_d;
      rw_q             <= rw_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      mode_q           <= mode_d;
      busy_q           <= busy_d;
      rdata_q          <= rdata_d;
      rdata_valid_q    <= rdata_valid_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

  // Next state; bus outputs are computed for the state being entered so they register in step
  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rx_d             = rx_q;
    rx_cnt_d         = rx_cnt_q;
    tmo_d            = tmo_q;
    rw_d             = rw_q;
    rdata_d          = rdata_q;
    data_out_d       = 1'b0;
    data_out_valid_d = 1'b0;
    mode_d           = 1'b0;
    rdata_valid_d    = 1'b0;
    done_d           = 1'b0;
    error_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_req) begin
          addr_d           = init_addr;
          wdata_d          = init_wdata;
          rw_d             = init_rw;
          rx_d             = '0;
          rx_cnt_d         = '0;
          bit_cnt_d        = '0;
          data_out_d       = init_addr[0];
          data_out_valid_d = 1'b1;
          state_d          = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
          bit_cnt_d = '0;
          tmo_d     = '0;
          if (rw_q) begin
            data_out_d       = wdata_q[0];
            data_out_valid_d = 1'b1;
            mode_d           = 1'b1;
            state_d          = S_WDATA;
          end else begin
            state_d = S_RDATA;
          end
        end else begin
          bit_cnt_d        = bit_cnt_q + CNT_W'(1);
          data_out_d       = addr_q[bit_cnt_d];
          data_out_valid_d = 1'b1;
        end
      end
      S_WDATA: begin
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          tmo_d   = '0;
          state_d = S_WAIT_ACK;
        end else begin
          bit_cnt_d        = bit_cnt_q + CNT_W'(1);
          data_out_d       = wdata_q[bit_cnt_d[RXC_W-1:0]];
          data_out_valid_d = 1'b1;
          mode_d           = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (bus_target_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RDATA: begin
        // A received bit always beats a coincident timeout
        if (bus_data_in_valid) begin
          rx_d[rx_cnt_q] = bus_data_in;
          rx_cnt_d       = rx_cnt_q + RXC_W'(1);
          tmo_d          = '0;
          if (rx_cnt_q == RXC_W'(DATA_W - 1)) begin
            rdata_d       = rx_d;
            rdata_valid_d = 1'b1;
            done_d        = 1'b1;
            state_d       = S_IDLE;
          end
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus_data_out       = data_out_q;
  assign bus_data_out_valid = data_out_valid_q;
  assign bus_mode           = mode_q;
  assign bus_rw             = rw_q;
  assign init_busy          = busy_q;
  assign init_rdata         = rdata_q;
  assign init_rdata_valid   = rdata_valid_q;
  assign init_done          = done_q;
  assign init_error         = error_q;

endmodule

// File: tb/tb_initiator_port.sv
// Directed and randomized transactions on initiator_port, checked against an
// outcome model (completion latency, error flag, read data) derived from the timing rules.
module tb_initiator_port;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic [15:0] init_addr;
  logic [7:0]  init_wdata;
  logic        init_rw;
  logic        bus_data_in;
  logic        bus_data_in_valid;
  logic        bus_target_ack;
  logic        bus_data_out;
  logic        bus_data_out_valid;
  logic        bus_mode;
  logic        bus_rw;
  logic        init_busy;
  logic [7:0]  init_rdata;
  logic        init_rdata_valid;
  logic        init_done;
  logic        init_error;

  int          n_cmp = 0;
  int          n_err = 0;
  int          gaps[8];
  logic [7:0]  exp_rdata;

  initiator_port #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .init_req          (init_req),
    .init_addr         (init_addr),
    .init_wdata        (init_wdata),
    .init_rw           (init_rw),
    .bus_data_in       (bus_data_in),
    .bus_data_in_valid (bus_data_in_valid),
    .bus_target_ack    (bus_target_ack),
    .bus_data_out      (bus_data_out),
    .bus_data_out_valid(bus_data_out_valid),
    .bus_mode          (bus_mode),
    .bus_rw            (bus_rw),
    .init_busy         (init_busy),
    .init_rdata        (init_rdata),
    .init_rdata_valid  (init_rdata_valid),
    .init_done         (init_done),
    .init_error        (init_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_dout"}, bus_data_out, 1'b0);
    chk1({tag, "_valid"}, bus_data_out_valid, 1'b0);
    chk1({tag, "_mode"}, bus_mode, 1'b0);
    chk1({tag, "_rw"}, bus_rw, 1'b0);
    chk1({tag, "_busy"}, init_busy, 1'b0);
    chk32({tag, "_rdata"}, 32'(init_rdata), 32'h0);
    chk1({tag, "_rvalid"}, init_rdata_valid, 1'b0);
    chk1({tag, "_done"}, init_done, 1'b0);
    chk1({tag, "_error"}, init_error, 1'b0);
  endtask

  // Outcome model: write succeeds iff ack arrives within T idle cycles; a read needs
  // every one of 8 bits to arrive no more than T idle cycles after the previous reset point.
  function automatic void predict(input logic rw, input int d, input int nb,
                                  output bit err, output int lat);
    int  s;
    bit  stop;
    err  = 1'b0;
    lat  = 0;
    if (rw) begin
      if (d <= T) lat = d + 1;
      else begin err = 1'b1; lat = T + 1; end
    end else begin
      s    = 0;
      stop = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (!stop) begin
          if (j >= nb || gaps[j] > T) begin
            err  = 1'b1;
            lat  = s + T + 1;
            stop = 1'b1;
          end else begin
            s = s + gaps[j] + 1;
          end
        end
      end
      if (!stop) lat = s;
    end
  endfunction

  task automatic scramble();
    init_addr  = 16'($urandom);
    init_wdata = 8'($urandom);
    init_rw    = 1'($urandom);
  endtask

  task automatic run_txn(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                         input int d, input logic [7:0] rb, input int nb,
                         input bit hold, input int rst_at);
    int  k, j, s, exp_lat;
    bit  done_seen, exp_err;
    chk1("idle_busy", init_busy, 1'b0);
    chk1("idle_valid", bus_data_out_valid, 1'b0);
    init_req   = 1'b1;
    init_addr  = a;
    init_wdata = wd;
    init_rw    = rw;
    step();
    if (!hold) init_req = 1'b0;
    chk1("done_one_cycle", init_done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk1("addr_bit", bus_data_out, a[i]);
      chk1("addr_valid", bus_data_out_valid, 1'b1);
      chk1("addr_mode", bus_mode, 1'b0);
      chk1("addr_bus_rw", bus_rw, rw);
      chk1("addr_busy", init_busy, 1'b1);
      if (i == rst_at) begin
        rst      = 1'b1;
        init_req = 1'b0;
        step();
        rst = 1'b0;
        exp_rdata = 8'h00;
        chk_all_zero("mid_reset");
        repeat (3) begin
          step();
          chk1("post_reset_done", init_done, 1'b0);
          chk1("post_reset_valid", bus_data_out_valid, 1'b0);
        end
        return;
      end
      if (hold) scramble();
      bus_target_ack    = 1'($urandom);
      bus_data_in_valid = 1'($urandom);
      bus_data_in       = 1'($urandom);
      step();
    end
    if (rw) begin
      for (int i = 0; i < 8; i++) begin
        chk1("wdata_bit", bus_data_out, wd[i]);
        chk1("wdata_valid", bus_data_out_valid, 1'b1);
        chk1("wdata_mode", bus_mode, 1'b1);
        chk1("wdata_bus_rw", bus_rw, 1'b1);
        if (hold) scramble();
        bus_target_ack    = 1'($urandom);
        bus_data_in_valid = 1'($urandom);
        step();
      end
    end
    predict(rw, d, nb, exp_err, exp_lat);
    k = 0; j = 0; s = 0; done_seen = 1'b0;
    while (!done_seen && k < 400) begin
      chk1("wait_valid", bus_data_out_valid, 1'b0);
      chk1("wait_dout", bus_data_out, 1'b0);
      chk1("wait_mode", bus_mode, 1'b0);
      chk1("wait_busy", init_busy, 1'b1);
      if (rw) begin
        bus_target_ack    = (k == d);
        bus_data_in_valid = 1'($urandom);
        bus_data_in       = 1'($urandom);
      end else begin
        bus_target_ack = 1'($urandom);
        if (j < nb && k == s + gaps[j]) begin
          bus_data_in_valid = 1'b1;
          bus_data_in       = rb[j];
          s = k + 1;
          j++;
        end else begin
          bus_data_in_valid = 1'b0;
          bus_data_in       = 1'($urandom);
        end
      end
      if (hold) scramble();
      step();
      k++;
      bus_target_ack    = 1'b0;
      bus_data_in_valid = 1'b0;
      if (init_done === 1'b1) done_seen = 1'b1;
    end
    chk32("done_latency", 32'(k), 32'(exp_lat));
    chk1("done_pulse", init_done, 1'b1);
    chk1("done_error", init_error, exp_err);
    chk1("done_rvalid", init_rdata_valid, !rw && !exp_err);
    chk1("done_busy", init_busy, 1'b0);
    chk1("done_valid", bus_data_out_valid, 1'b0);
    if (!rw && !exp_err) exp_rdata = rb;
    chk32("done_rdata", 32'(init_rdata), 32'(exp_rdata));
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; init_addr = '0; init_wdata = '0; init_rw = 1'b0;
    bus_data_in = 1'b0; bus_data_in_valid = 1'b0; bus_target_ack = 1'b0;
    exp_rdata = 8'h00;
    foreach (gaps[i]) gaps[i] = 0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // Write with ack three cycles after the data phase
    run_txn(1'b1, 16'hA5C3, 8'h5A, 3, 8'h00, 8, 1'b0, -1);
    step();
    // Read returning B4 with two-cycle gaps
    foreach (gaps[i]) gaps[i] = 2;
    run_txn(1'b0, 16'h0012, 8'h00, 0, 8'hB4, 8, 1'b0, -1);
    step();
    // Write without ack times out
    run_txn(1'b1, 16'h1234, 8'hC3, 1000, 8'h00, 8, 1'b0, -1);
    step();
    // Read with only five bits returned
    foreach (gaps[i]) gaps[i] = 1;
    run_txn(1'b0, 16'hBEEF, 8'h00, 0, 8'h6D, 5, 1'b0, -1);
    step();
    // Ack and 8th bit exactly at expiry win
    run_txn(1'b1, 16'h0F0F, 8'hA1, T, 8'h00, 8, 1'b0, -1);
    foreach (gaps[i]) gaps[i] = 0;
    gaps[7] = T;
    run_txn(1'b0, 16'hF00D, 8'h00, 0, 8'h9C, 8, 1'b0, -1);
    step();
    // Reset during the 10th address bit, then a normal write
    run_txn(1'b1, 16'h7E81, 8'h33, 2, 8'h00, 8, 1'b0, 9);
    run_txn(1'b1, 16'h3C5A, 8'hE7, 1, 8'h00, 8, 1'b0, -1);
    // Request held high: back-to-back with one idle cycle
    foreach (gaps[i]) gaps[i] = 1;
    run_txn(1'b1, 16'h8001, 8'h81, 0, 8'h00, 8, 1'b1, -1);
    run_txn(1'b0, 16'h4002, 8'h00, 0, 8'h2B, 8, 1'b1, -1);
    run_txn(1'b1, 16'h2004, 8'h42, 5, 8'h00, 8, 1'b1, -1);
    init_req = 1'b0;
    step();

    for (int n = 0; n < 14; n++) begin
      logic       rw;
      int         d, nb;
      bit         hold;
      rw   = 1'($urandom);
      d    = ($urandom_range(0, 5) == 0) ? 70 : int'($urandom_range(0, 6));
      nb   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 8;
      hold = 1'($urandom);
      foreach (gaps[i]) gaps[i] = int'($urandom_range(0, 3));
      run_txn(rw, 16'($urandom), 8'($urandom), d, 8'($urandom), nb, hold, -1);
    end
    init_req = 1'b0;
    step();
    chk1("final_idle_busy", init_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
